// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, ring entry layout, defaults.
package ifetch_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int ENTRY_XLEN    = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] data;
    logic                  done;
    logic                  fault;
  } entry_t;

endpackage

// File: rtl/ifetch_buffer.sv
// Ring buffer pairing fetch PCs with in-order memory responses (alloc -> fill -> head).
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  alloc,
  input  logic [ENTRY_XLEN-1:0] alloc_pc,
  input  logic                  alloc_fault,
  input  logic                  fill,
  input  logic [ENTRY_XLEN-1:0] fill_data,
  input  logic                  pop,
  output entry_t                head,
  output logic [CW-1:0]         used
);

  entry_t          ring [DEPTH];
  logic [AW-1:0]   alloc_ptr;
  logic [AW-1:0]   fill_ptr;
  logic [AW-1:0]   head_ptr;

  // Popped and flushed slots get done cleared so an empty ring never shows a stale entry at head.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      used      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
    end else begin
      if (alloc) begin
        ring[alloc_ptr] <= '{pc: alloc_pc, data: '0, done: alloc_fault, fault: alloc_fault};
        alloc_ptr       <= alloc_ptr + AW'(1);
      end
      if (fill) begin
        ring[fill_ptr].data <= fill_data;
        ring[fill_ptr].done <= 1'b1;
        fill_ptr            <= fill_ptr + AW'(1);
      end
      if (pop) begin
        ring[head_ptr].done <= 1'b0;
        head_ptr            <= head_ptr + AW'(1);
      end
      used <= used + CW'(alloc) - CW'(pop);
    end
  end

  assign head = ring[head_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests, buffers responses, hands {inst, pc} to decode.
// Optional misaligned-fetch fault generation is enabled by defining FETCH_ALIGN_CHECK_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int XLEN  = ENTRY_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            flush_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o,
  output state_t          dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens in a cycle where valid & ready are both high at the clock edge;
  // valid never waits on ready, and imem responses cannot be back-pressured.
  state_t        state, state_next;
  logic [CW-1:0] pend_cnt, pend_next;
  logic [CW-1:0] used;
  logic          alloc, alloc_fault, fill, pop, clear, misaligned;
  entry_t        head;

  ifetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .alloc       (alloc),
    .alloc_pc    (pc_i),
    .alloc_fault (alloc_fault),
    .fill        (fill),
    .fill_data   (imem_rsp_data_i),
    .pop         (pop),
    .head        (head),
    .used        (used)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned   = (pc_i[1:0] != 2'b00);
  assign inst_fault_o = head.fault;
`else
  logic unused_fault;
  assign misaligned   = 1'b0;
  assign inst_fault_o = 1'b0;
  assign unused_fault = head.fault;
`endif

  assign imem_addr_o = pc_i;
  assign inst_o      = head.data;
  assign inst_pc_o   = head.pc;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pend_cnt <= '0;
    end else begin
      state    <= state_next;
      pend_cnt <= pend_next;
    end
  end

  // pend_cnt counts requests awaiting a response; in DRAIN it is the number still to be dropped.
  always_comb begin
    state_next       = state;
    pend_next        = pend_cnt;
    imem_req_valid_o = 1'b0;
    pc_en_o          = 1'b0;
    alloc            = 1'b0;
    alloc_fault      = 1'b0;
    fill             = 1'b0;
    pop              = 1'b0;
    clear            = 1'b0;
    inst_valid_o     = head.done & ~flush_i & ~reset;
    if (reset) begin
      state_next = FETCH;
    end else if (flush_i) begin
      clear      = 1'b1;
      pend_next  = pend_cnt - CW'(imem_rsp_valid_i);
      state_next = (pend_next != '0) ? DRAIN : FETCH;
    end else begin
      if (state == FETCH && used < CW'(DEPTH)) begin
        if (misaligned) begin
          alloc       = 1'b1;
          alloc_fault = 1'b1;
          state_next  = FAULT;
        end else begin
          imem_req_valid_o = 1'b1;
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        alloc   = 1'b1;
        pc_en_o = 1'b1;
      end
      fill      = imem_rsp_valid_i & (state != DRAIN);
      pend_next = pend_cnt + CW'(pc_en_o) - CW'(imem_rsp_valid_i);
      if (state == DRAIN && pend_next == '0) begin
        state_next = FETCH;
      end
      pop = inst_valid_o & inst_ready_i;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order memory model and expected-instruction scoreboard.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc_i;
  logic            pc_en_o;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_rsp_valid_i;
  logic [XLEN-1:0] imem_rsp_data_i;
  logic            flush_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_fault_o;
  state_t          dbg_state;

  ifetch_unit #(.DEPTH(4), .XLEN(XLEN)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .pc_en_o          (pc_en_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .flush_i          (flush_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o),
    .dbg_state        (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard and models
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [64:0] exp_q[$];    // {fault, pc, inst}

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          stale_cnt = 0;
  int          accs, pops, first_acc, first_pop;
  int          imem_ready_mode, inst_ready_mode, lat_min, lat_max;
  bit          flush_req;
  bit          capture_first;
  logic [31:0] pc, redirect, first_pc;
  logic        obs_req_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver: one clock cycle of memory, PC register and decode behaviour.
  task automatic step();
    int          lat, due;
    logic        acc, popped;
    logic [64:0] e;
    @(negedge clk);
    case (imem_ready_mode)
      0:       imem_req_ready_i = 1'b0;
      1:       imem_req_ready_i = 1'b1;
      default: imem_req_ready_i = 1'($urandom_range(0, 1));
    endcase
    case (inst_ready_mode)
      0:       inst_ready_i = 1'b0;
      1:       inst_ready_i = 1'b1;
      default: inst_ready_i = 1'($urandom_range(0, 1));
    endcase
    flush_i          = flush_req;
    pc_i             = pc;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(mem_q[0].addr);
      if (mem_q[0].stale) stale_cnt--;
      void'(mem_q.pop_front());
    end
    #1;
    acc           = imem_req_valid_o & imem_req_ready_i;
    popped        = inst_valid_o & inst_ready_i;
    obs_req_valid = imem_req_valid_o;
    check_eq("pc_en", 32'(pc_en_o), 32'(acc));
    if (imem_req_valid_o) check_eq("imem_addr", imem_addr_o, pc);
    if (flush_i) begin
      check_eq("flush_no_req", 32'(imem_req_valid_o), 32'd0);
      check_eq("flush_no_pop", 32'(inst_valid_o), 32'd0);
    end else if (stale_cnt > 0) begin
      check_eq("drain_no_req", 32'(imem_req_valid_o), 32'd0);
    end
    if (popped) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      if (capture_first) begin
        first_pc      = inst_pc_o;
        capture_first = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check_eq("pop_without_expect", 32'(inst_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("inst_pc", inst_pc_o, e[63:32]);
        check_eq("inst", inst_o, e[31:0]);
        check_eq("inst_fault", 32'(inst_fault_o), 32'(e[64]));
      end
    end
    if (acc) begin
      accs++;
      if (first_acc < 0) first_acc = cyc;
      lat = $urandom_range(lat_min, lat_max);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: pc, due: due, stale: 1'b0});
      exp_q.push_back({1'b0, pc, mem_word(pc)});
      pc = pc + 32'd4;
    end
    if (flush_i) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      stale_cnt = mem_q.size();
      exp_q.delete();
      pc        = redirect;
      flush_req = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    imem_ready_mode = 0;
    inst_ready_mode = 1;
    repeat (n) step();
    check_eq("drain_idle_valid", 32'(inst_valid_o), 32'd0);
    check_eq("drain_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  // Flush, wait out the dropped responses, then expect requests to resume immediately.
  task automatic flush_and_resume(input logic [31:0] target, input string tag);
    redirect      = target;
    flush_req     = 1'b1;
    capture_first = 1'b1;
    step();
    for (int i = 0; i < 20 && stale_cnt > 0; i++) step();
    step();
    check_eq(tag, 32'(obs_req_valid), 32'd1);
    repeat (10) step();
    check_eq({tag, "_first_pc"}, first_pc, target);
  endtask

  initial begin
    reset            = 1'b1;
    pc_i             = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    flush_i          = 1'b0;
    inst_ready_i     = 1'b0;
    pc               = 32'h0;
    redirect         = 32'h0;
    first_pc         = 32'h0;
    flush_req        = 1'b0;
    capture_first    = 1'b0;
    imem_ready_mode  = 0;
    inst_ready_mode  = 1;
    lat_min          = 1;
    lat_max          = 1;
    accs = 0; pops = 0; first_acc = -1; first_pop = -1;

    // Reset values, sampled with reset still asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check_eq("rst_pc_en", 32'(pc_en_o), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    check_eq("rst_inst_fault", 32'(inst_fault_o), 32'd0);
    check_eq("rst_inst", inst_o, 32'd0);
    check_eq("rst_inst_pc", inst_pc_o, 32'd0);
    reset = 1'b0;

    // Fixed latency 1, decode always ready: 2-cycle fill latency, then one instruction per cycle
    imem_ready_mode = 1;
    repeat (12) step();
    check_eq("first_latency", 32'(first_pop - first_acc), 32'd2);
    check_eq("throughput", 32'(pops), 32'd10);
    drain(6);

    // Decode stalled: exactly DEPTH requests accepted, then requests stop
    accs = 0; pops = 0;
    imem_ready_mode = 1;
    inst_ready_mode = 0;
    repeat (10) step();
    check_eq("stall_accepts", 32'(accs), 32'd4);
    check_eq("stall_req_valid", 32'(obs_req_valid), 32'd0);
    check_eq("stall_pc_en", 32'(pc_en_o), 32'd0);
    imem_ready_mode = 0;
    inst_ready_mode = 1;
    repeat (8) step();
    check_eq("release_pops", 32'(pops), 32'd4);
    drain(4);

    // Random latency 1..5 with both ready signals toggling
    lat_min = 1; lat_max = 5;
    imem_ready_mode = 2;
    inst_ready_mode = 2;
    repeat (300) step();
    drain(20);

    // Flush with three requests in flight (latency 5): all three dropped
    lat_min = 5; lat_max = 5;
    imem_ready_mode = 1;
    inst_ready_mode = 1;
    for (int i = 0; i < 10 && mem_q.size() < 3; i++) step();
    check_eq("flush3_setup", 32'(mem_q.size()), 32'd3);
    flush_and_resume(32'h100, "flush3_resume");
    drain(10);

    // Flush coinciding with a response and a pop in steady latency-2 streaming
    lat_min = 2; lat_max = 2;
    imem_ready_mode = 1;
    repeat (8) step();
    flush_and_resume(32'h200, "flush_coincident_resume");
    drain(10);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC: fault entry delivered, no requests until the next flush
    imem_ready_mode = 1;
    redirect  = 32'h102;
    flush_req = 1'b1;
    step();
    exp_q.push_back({1'b1, 32'h102, 32'h0});
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("fault_no_req", 32'(obs_req_valid), 32'd0);
    end
    check_eq("fault_pops", 32'(pops), 32'd1);
    redirect  = 32'h0;
    flush_req = 1'b1;
    step();
    step();
    check_eq("fault_exit_req", 32'(obs_req_valid), 32'd1);
    drain(10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
